// File: rtl/wallace_pkg.sv
// Shared widths, kpg encoding and Baugh-Wooley constant for the WallacePL front half.
package wallace_pkg;
    localparam int OP_W  = 8;
    localparam int ROW_W = 16;

    typedef logic [1:0] kpg_t;
    localparam kpg_t KPG_KILL = 2'b00;

    localparam logic [ROW_W-1:0] BW_CONST = 16'h8100;

    typedef logic [OP_W-1:0][ROW_W-1:0] pp_rows_t;
endpackage

// File: rtl/wallace_reduce_pl_csa_3to2.sv
// Row-wide 3:2 carry-save compressor: one full adder per bit, carry row pre-shifted left by 1.
module csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    // The top carry is always zero for in-range products, so truncation loses nothing.
    assign carry = {maj[W-2:0], 1'b0};
endmodule

// File: rtl/wallace_reduce_pl.sv
// Three-stage 8x8 partial-product generator + Wallace reducer to two carry-save rows.
// Optional signed (Baugh-Wooley) operands via macro WALLACE_SIGNED_EN.
module wallace_reduce_pl #(
    parameter int OP_W  = 8,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef WALLACE_SIGNED_EN
    input  logic              in_signed,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_row_a,
    output logic [2*OP_W-1:0] out_row_b,
    output logic [1:0]        out_k,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);
    import wallace_pkg::*;

    if (OP_W != 8) begin : g_bad_width
        $error("wallace_reduce_pl supports OP_W=8 only");
    end

    logic                  v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic                  adv0, adv1, adv2, acc;
    pp_rows_t              pp_in, pp_q, pp_d;
    logic [TAG_W-1:0]      tag0_q, tag0_d, tag1_q, tag1_d, tag2_q, tag2_d;
    logic [3:0][ROW_W-1:0] r1_q, r1_d;
    logic [ROW_W-1:0]      ra_q, ra_d, rb_q, rb_d;
    logic                  sgn0_q, sgn0_d;
    logic                  sgn_in;

`ifdef WALLACE_SIGNED_EN
    assign sgn_in = in_signed;
`else
    assign sgn_in = 1'b0;
`endif

    assign adv2     = v2_q && out_ready;
    assign adv1     = v1_q && (!v2_q || adv2);
    assign adv0     = v0_q && (!v1_q || adv1);
    assign in_ready = !v0_q || adv0;
    assign acc      = in_valid && in_ready;

    // Partial products; signed mode flips the sign-weighted bits (Baugh-Wooley).
    always_comb begin
        pp_in = '0;
        for (int i = 0; i < OP_W; i++) begin
            pp_in[i][i +: OP_W] = in_a & {OP_W{in_b[i]}};
            if (sgn_in) begin
                if (i < OP_W - 1) pp_in[i][i+OP_W-1] = ~pp_in[i][i+OP_W-1];
                else              pp_in[i][2*OP_W-3:OP_W-1] = ~pp_in[i][2*OP_W-3:OP_W-1];
            end
        end
    end

    // S1 level 1: 8 (or 9 with the signed constant row) -> 6 rows.
    logic [ROW_W-1:0] l1 [6];
    logic [ROW_W-1:0] l2 [4];
    logic [ROW_W-1:0] l3_s, l3_c, l4_s, l4_c;

    csa_3to2 #(.W(ROW_W)) u_l1_0 (.x(pp_q[0]), .y(pp_q[1]), .z(pp_q[2]), .sum(l1[0]), .carry(l1[1]));
    csa_3to2 #(.W(ROW_W)) u_l1_1 (.x(pp_q[3]), .y(pp_q[4]), .z(pp_q[5]), .sum(l1[2]), .carry(l1[3]));
`ifdef WALLACE_SIGNED_EN
    logic [ROW_W-1:0] bw_row;
    assign bw_row = sgn0_q ? BW_CONST : '0;
    csa_3to2 #(.W(ROW_W)) u_l1_2 (.x(pp_q[6]), .y(pp_q[7]), .z(bw_row), .sum(l1[4]), .carry(l1[5]));
`else
    assign l1[4] = pp_q[6];
    assign l1[5] = pp_q[7];
`endif

    // S1 level 2: 6 -> 4 rows.
    csa_3to2 #(.W(ROW_W)) u_l2_0 (.x(l1[0]), .y(l1[1]), .z(l1[2]), .sum(l2[0]), .carry(l2[1]));
    csa_3to2 #(.W(ROW_W)) u_l2_1 (.x(l1[3]), .y(l1[4]), .z(l1[5]), .sum(l2[2]), .carry(l2[3]));

    // S2: 4 -> 3 -> 2 rows.
    csa_3to2 #(.W(ROW_W)) u_l3 (.x(r1_q[0]), .y(r1_q[1]), .z(r1_q[2]), .sum(l3_s), .carry(l3_c));
    csa_3to2 #(.W(ROW_W)) u_l4 (.x(l3_s), .y(l3_c), .z(r1_q[3]), .sum(l4_s), .carry(l4_c));

    always_comb begin
        v0_d   = acc  ? 1'b1 : (adv0 ? 1'b0 : v0_q);
        v1_d   = adv0 ? 1'b1 : (adv1 ? 1'b0 : v1_q);
        v2_d   = adv1 ? 1'b1 : (adv2 ? 1'b0 : v2_q);
        pp_d   = acc  ? pp_in  : pp_q;
        tag0_d = acc  ? in_tag : tag0_q;
        sgn0_d = acc  ? sgn_in : sgn0_q;
        r1_d   = adv0 ? {l2[3], l2[2], l2[1], l2[0]} : r1_q;
        tag1_d = adv0 ? tag0_q : tag1_q;
        ra_d   = adv1 ? l4_s   : ra_q;
        rb_d   = adv1 ? l4_c   : rb_q;
        tag2_d = adv1 ? tag1_q : tag2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0;
            pp_q <= '0;   tag0_q <= '0; sgn0_q <= 1'b0;
            r1_q <= '0;   tag1_q <= '0;
            ra_q <= '0;   rb_q <= '0;   tag2_q <= '0;
        end else begin
            v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d;
            pp_q <= pp_d; tag0_q <= tag0_d; sgn0_q <= sgn0_d;
            r1_q <= r1_d; tag1_q <= tag1_d;
            ra_q <= ra_d; rb_q <= rb_d; tag2_q <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_row_a = ra_q;
    assign out_row_b = rb_q;
    assign out_tag   = tag2_q;
    assign out_k     = KPG_KILL;
    assign busy      = v0_q | v1_q | v2_q;
endmodule

// File: doc/wallace_reduce_pl.md
Name: wallace_reduce_pl

Overview:
- Pipelined 8x8 partial-product generator and Wallace-tree reducer; the front half of the WallacePL multiplier.
- Compresses 8 partial-product rows into two 16-bit carry-save rows.
- Feeds sum16bit directly: out_row_a -> a, out_row_b -> b, out_k -> kIn.
- Three register stages with a valid/ready handshake, so backpressure from the adder side stalls the tree without loss.

Parameters:
- OP_W, 8, operand width (only 8 supported; asserted at elaboration).
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept this cycle.
- in_a  in  OP_W  multiplicand.
- in_b  in  OP_W  multiplier.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  carry-save result present.
- out_ready  in  1  downstream accepts.
- out_row_a  out  2*OP_W  carry-save row 0.
- out_row_b  out  2*OP_W  carry-save row 1.
- out_k  out  2  carry-in to the adder in kpg encoding; always KPG_KILL (2'b00).
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  any stage valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all stage valid bits 0; out_valid=0; busy=0.
  - out_row_a, out_row_b, out_tag all 0.
  - out_k=2'b00.
  - in_ready=1 in the first cycle after reset.
- S0 (on accept): register pp[i] = (in_a & {8{in_b[i]}}) << i, for i=0..7, plus the tag.
- S1: two levels of 3:2 compression (8->6->4 rows); register the 4 rows.
- S2: 4->3->2 rows; register as out_row_a/out_row_b.
- Arithmetic rule: out_row_a + out_row_b, taken to 17 bits, == in_a*in_b exactly (bit 16 = 0).
  - No carry beyond bit 15 may be dropped in any level.
- Latency: a pair accepted at edge E appears with out_valid=1 after edge E+2.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Handshake:
  - Stage k advances when valid_k && (!valid_{k+1} || advance_{k+1}).
  - S2 advance = out_valid && out_ready.
  - in_ready = !valid_S0 || advance_S0 (combinational, no bubble).
- Stall hold:
  - While out_valid && !out_ready, out_row_a/out_row_b/out_tag hold stable.
  - Upstream bubbles collapse; S0/S1 fill, then in_ready drops.
- Simultaneous events:
  - Output drain and input accept in the same cycle are both honoured.
  - The pipeline never holds more than 3 operations.
- Reset mid-operation: all in-flight work is discarded; no partial result emerges.
- in_valid with in_ready=0: inputs are ignored; the source must hold them.
- busy = valid_S0 | valid_S1 | valid_S2.

Optional Feature:
- Macro WALLACE_SIGNED_EN.
- Defined:
  - Adds input port in_signed (1 bit), carried through the stages with the data.
  - When in_signed=1, operands are two's complement, handled by the Baugh-Wooley method:
    - pp[i][7] inverted for i<7.
    - pp[7][6:0] inverted.
    - constant 2^8 + 2^15 injected as an extra S0 row.
  - Requirement: (out_row_a + out_row_b) mod 2^16 == signed product; bit 16 is don't-care.
- Undefined: no in_signed port; unsigned only; the extra row logic is absent.

Decomposition:
- Package wallace_pkg:
  - OP_W and ROW_W=16.
  - kpg typedef kpg_t (2 bits) and constant KPG_KILL=2'b00.
  - BW_CONST=16'h8100.
  - typedef pp_rows_t (array of 8 ROW_W rows).
- Sub-module csa_3to2: parameterised-width row compressor (full adder per bit; carry shifted left 1). Instantiated per compression group.

Test Plan:
- Reset then in_a=8'hFF, in_b=8'hFF, in_tag=4'h5, out_ready=1 -> out_valid after 2 edges; row_a+row_b=17'h0FE01; out_tag=5; out_k=2'b00.
- Back-to-back {8'h99,8'hFF}, {8'h9A,8'h00}, {8'h01,8'h01} -> results 16'h9867, 0, 1 on consecutive cycles, in order, no bubbles.
- out_ready=0 for 5 cycles while feeding 4 ops -> in_ready drops after 3 accepted; outputs stable; after release all 4 emerge in order with correct products.
- rst asserted with 3 ops in flight -> next cycle out_valid=0, busy=0, rows=0; no stale result afterwards.
- Random 10k pairs with random out_ready -> every row sum equals the product; tags preserved in order.
- WALLACE_SIGNED_EN: 8'h80*8'h80 signed -> sum mod 2^16 = 16'h4000; 8'hFF*8'h02 signed -> 16'hFFFE; the same pairs with in_signed=0 -> 16'h4000, 16'h01FE.
